// File: rtl/sift_offset_refine.sv
// Sub-pixel keypoint offset -N/det with one shared restoring divider.
// Components x, y, s are divided in turn, then signed, saturated and flagged.
module sift_offset_refine #(
    parameter int FRAC_BITS = 8,
    parameter int DET_W     = 27,
    parameter int OUT_W     = 12
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             ivalid,
    output logic             oready,
    input  logic [18:0]      idata11,
    input  logic [18:0]      idata21,
    input  logic [18:0]      idata31,
    input  logic [DET_W-1:0] idet,
    output logic             ovalid,
    input  logic             iready,
    output logic [OUT_W-1:0] ooffset_x,
    output logic [OUT_W-1:0] ooffset_y,
    output logic [OUT_W-1:0] ooffset_s,
    output logic             okeep
);

    localparam int ITER = 19 + FRAC_BITS;
    localparam int DW   = 19 + FRAC_BITS;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [OUT_W-2:0] MAXM = '1;
    localparam logic [OUT_W-2:0] HALF =
        {{(OUT_W-1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [1:0]       comp;
    logic [DET_W:0]   rem;
    logic [DW-1:0]    quo;
    logic [DW-1:0]    qx, qy, qs;
    logic [18:0]      my, ms;
    logic             sx, sy, ss;
    logic             dneg, dzero;
    logic [DET_W-1:0] dabs;

    function automatic logic [18:0] mag19(input logic [18:0] v);
        return v[18] ? ~v + 19'd1 : v;
    endfunction

    function automatic logic [DET_W-1:0] magd(input logic [DET_W-1:0] v);
        return v[DET_W-1] ? ~v + DET_W'(1) : v;
    endfunction

    function automatic logic [OUT_W-2:0] sat(input logic [DW-1:0] q);
        return (q > DW'(MAXM)) ? MAXM : q[OUT_W-2:0];
    endfunction

    // Offset is -N/det, so equal operand signs give a negative result.
    function automatic logic [OUT_W-1:0] signed_out(
        input logic [OUT_W-2:0] m,
        input logic             sn,
        input logic             sd
    );
        return (sn == sd && m != '0) ? -{1'b0, m} : {1'b0, m};
    endfunction

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [DET_W:0] rem_sh, rem_sub;
    logic           ge;
    logic [DW-1:0]  quo_nxt;

    always_comb begin
        rem_sh  = {rem[DET_W-1:0], quo[DW-1]};
        ge      = rem[DET_W] | (rem_sh >= {1'b0, dabs});
        rem_sub = rem_sh - {1'b0, dabs};
        quo_nxt = {quo[DW-2:0], ge};
    end

    logic [OUT_W-2:0] mx, my_s, ms_s;
    logic             keep_nxt;

    always_comb begin
        mx       = sat(qx);
        my_s     = sat(qy);
        ms_s     = sat(qs);
        keep_nxt = !dzero && mx <= HALF && my_s <= HALF && ms_s <= HALF;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (ivalid) state_nxt = (idet == '0) ? FIN : DIV;
            DIV:  if (cnt == LAST && comp == 2'd2) state_nxt = FIN;
            FIN:  state_nxt = DONE;
            DONE: if (iready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            cnt       <= '0;
            comp      <= '0;
            rem       <= '0;
            quo       <= '0;
            qx        <= '0;
            qy        <= '0;
            qs        <= '0;
            my        <= '0;
            ms        <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            ss        <= 1'b0;
            dneg      <= 1'b0;
            dzero     <= 1'b0;
            dabs      <= '0;
            ooffset_x <= '0;
            ooffset_y <= '0;
            ooffset_s <= '0;
            okeep     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (ivalid) begin
                    my    <= mag19(idata21);
                    ms    <= mag19(idata31);
                    sx    <= idata11[18];
                    sy    <= idata21[18];
                    ss    <= idata31[18];
                    dneg  <= idet[DET_W-1];
                    dzero <= (idet == '0);
                    dabs  <= magd(idet);
                    comp  <= '0;
                    cnt   <= '0;
                    rem   <= '0;
                    quo   <= {mag19(idata11), {FRAC_BITS{1'b0}}};
                end
                DIV: begin
                    if (cnt == LAST) begin
                        case (comp)
                            2'd0:    qx <= quo_nxt;
                            2'd1:    qy <= quo_nxt;
                            default: qs <= quo_nxt;
                        endcase
                        cnt  <= '0;
                        rem  <= '0;
                        comp <= comp + 2'd1;
                        quo  <= {(comp == 2'd0) ? my : ms, {FRAC_BITS{1'b0}}};
                    end else begin
                        cnt <= cnt + CW'(1);
                        rem <= ge ? rem_sub : rem_sh;
                        quo <= quo_nxt;
                    end
                end
                FIN: begin
                    ooffset_x <= dzero ? '0 : signed_out(mx, sx, dneg);
                    ooffset_y <= dzero ? '0 : signed_out(my_s, sy, dneg);
                    ooffset_s <= dzero ? '0 : signed_out(ms_s, ss, dneg);
                    okeep     <= keep_nxt;
                end
                default: ;
            endcase
        end
    end

    assign ovalid = (state == DONE);
    assign oready = (state == IDLE);

endmodule

// File: tb/tb_sift_offset_refine.sv
// Randomized bench for sift_offset_refine against an arithmetic model.
module tb_sift_offset_refine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ivalid;
    logic        oready;
    logic [18:0] d11, d21, d31;
    logic [26:0] det;
    logic        ovalid;
    logic        iready;
    logic [11:0] ox, oy, os;
    logic        keep;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sift_offset_refine dut (
        .iclk      (clk),
        .irst_n    (rst_n),
        .ivalid    (ivalid),
        .oready    (oready),
        .idata11   (d11),
        .idata21   (d21),
        .idata31   (d31),
        .idet      (det),
        .ovalid    (ovalid),
        .iready    (iready),
        .ooffset_x (ox),
        .ooffset_y (oy),
        .ooffset_s (os),
        .okeep     (keep)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_off(input int n, input int d);
        longint v;
        if (d == 0) return 0;
        v = -(longint'(n) * 256) / longint'(d);
        if (v > 2047)  v = 2047;
        if (v < -2047) v = -2047;
        return v;
    endfunction

    function automatic longint sx12(input logic [11:0] v);
        return longint'($signed(v));
    endfunction

    task automatic run(input int n1, input int n2, input int n3, input int d,
                       input int hold, input string tag);
        longint ex, ey, es;
        longint ek;
        int     lat;
        ex = model_off(n1, d);
        ey = model_off(n2, d);
        es = model_off(n3, d);
        ek = (d != 0 && ex <= 128 && ex >= -128 && ey <= 128 && ey >= -128 &&
              es <= 128 && es >= -128) ? 1 : 0;
        @(negedge clk);
        d11    = 19'(n1);
        d21    = 19'(n2);
        d31    = 19'(n3);
        det    = 27'(d);
        ivalid = 1'b1;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        check({tag, ":busy_ready"}, longint'(oready), 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ovalid && lat < 200);
        check({tag, ":latency"}, lat, (d == 0) ? 1 : 82);
        check({tag, ":x"}, sx12(ox), ex);
        check({tag, ":y"}, sx12(oy), ey);
        check({tag, ":s"}, sx12(os), es);
        check({tag, ":keep"}, longint'(keep), ek);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({tag, ":hold_valid"}, longint'(ovalid), 1);
            check({tag, ":hold_ready"}, longint'(oready), 0);
            check({tag, ":hold_x"}, sx12(ox), ex);
            check({tag, ":hold_keep"}, longint'(keep), ek);
        end
        iready = 1'b1;
        @(posedge clk);
        #1;
        iready = 1'b0;
        check({tag, ":released"}, longint'(ovalid), 0);
        check({tag, ":idle_ready"}, longint'(oready), 1);
    endtask

    initial begin
        logic signed [18:0] r19;
        logic signed [26:0] r27;
        int n[3];
        int d;

        rst_n  = 1'b0;
        ivalid = 1'b0;
        iready = 1'b0;
        d11    = '0;
        d21    = '0;
        d31    = '0;
        det    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", longint'(ovalid), 0);
        check("rst_ready", longint'(oready), 1);
        check("rst_x", sx12(ox), 0);
        check("rst_keep", longint'(keep), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(64, -32, 0, 256, 0, "basic");
        run(128, -256, 0, 256, 0, "half_edge");
        run(100, 1, -1, -400, 0, "trunc_zero");
        run(1, -262144, 262143, 1, 0, "saturate");
        run(-128, 128, 5, 256, 0, "neg_half");
        run(777, -5, 3, 0, 0, "det_zero");
        run(300, -300, 1000, -1000, 10, "stall");

        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r19 = 19'($urandom);
                    n[c] = int'(r19);
                end else begin
                    n[c] = int'($urandom_range(0, 400)) - 200;
                end
            end
            case ($urandom_range(0, 3))
                0: d = int'($urandom_range(1, 1000)) *
                       (($urandom_range(0, 1) == 1) ? 1 : -1);
                1: begin
                    r27 = 27'($urandom);
                    d = int'(r27);
                end
                2: d = 0;
                default: d = int'($urandom_range(1, 1 << 20)) *
                             (($urandom_range(0, 1) == 1) ? 1 : -1);
            endcase
            run(n[0], n[1], n[2], d, 0, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        d11    = 19'(1000);
        d21    = 19'(2000);
        d31    = 19'(3000);
        det    = 27'(7);
        ivalid = 1'b1;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", longint'(ovalid), 0);
        check("midrst_ready", longint'(oready), 1);
        check("midrst_x", sx12(ox), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("midrst_dropped", longint'(ovalid), 0);

        run(-200, 50, 1, 512, 0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
